// File: rtl/seq_detect_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
// Shared constants and helpers for the time-multiplexed serial pattern
// detector and the blocks around it.
//   DEF_PAT_LEN  : default pattern length in bits
//   DEF_PATTERN  : default target pattern, MSB is the earliest bit received
//   COUNT_W      : width of the optional per-channel match counters
//   chWidth()    : channel-ID width for a given channel count (min 1 bit)
// ---------------------------------------------------------------------------
package seq_detect_pkg;

  localparam int                     DEF_PAT_LEN = 7;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 7'b0110110;
  localparam int                     COUNT_W     = 8;

  // A single channel still needs one bit so that det_ch is never zero-width.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// ---------------------------------------------------------------------------
// seq_detect_scheduler_if
// Bundles the channel request/data side and the detection result of the
// shared pattern detector.
//   enable     : global run; 0 = no grants
//   ch_valid   : per-channel bit-available request
//   ch_bit     : per-channel serial data bit
//   clear_ch   : per-channel synchronous context clear
//   ch_ready   : one-hot grant back to the channels
//   det_valid  : one-cycle match pulse
//   det_ch     : channel that matched
//   rd_ch      : match-counter read select   (MATCH_COUNT_EN only)
//   rd_count   : match-counter read data     (MATCH_COUNT_EN only)
// Modports: master drives requests (front end / bench), slave is the detector.
// Optional feature macro: MATCH_COUNT_EN
// ---------------------------------------------------------------------------
interface seq_detect_scheduler_if
  import seq_detect_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = chWidth(N_CH)
);

  logic              enable;
  logic [N_CH-1:0]   ch_valid;
  logic [N_CH-1:0]   ch_bit;
  logic [N_CH-1:0]   clear_ch;
  logic [N_CH-1:0]   ch_ready;
  logic              det_valid;
  logic [CH_W-1:0]   det_ch;
`ifdef MATCH_COUNT_EN
  logic [CH_W-1:0]   rd_ch;
  logic [COUNT_W-1:0] rd_count;
`endif

`ifdef MATCH_COUNT_EN
  modport master (
    output enable, ch_valid, ch_bit, clear_ch, rd_ch,
    input  ch_ready, det_valid, det_ch, rd_count
  );
  modport slave (
    input  enable, ch_valid, ch_bit, clear_ch, rd_ch,
    output ch_ready, det_valid, det_ch, rd_count
  );
`else
  modport master (
    output enable, ch_valid, ch_bit, clear_ch,
    input  ch_ready, det_valid, det_ch
  );
  modport slave (
    input  enable, ch_valid, ch_bit, clear_ch,
    output ch_ready, det_valid, det_ch
  );
`endif

endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter: picks the first asserted request
// at or after ptr_i, wrapping from N_REQ-1 back to 0.
//   req_i   : request vector
//   ptr_i   : search start index (must be < N_REQ)
//   grant_o : one-hot grant, all zero when nothing requests
//   idx_o   : encoded index of the granted request (0 when none)
//   valid_o : a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Walk the rotated order from farthest to nearest so the last hit written
  // is the one closest to the pointer.
  always_comb begin
    int j;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (req_i[j]) begin
        idx_o   = IDX_W'(j);
        valid_o = 1'b1;
      end
    end
    if (valid_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// ---------------------------------------------------------------------------
// seq_detect_scheduler
// One shared serial pattern matcher serving N_CH bit-stream channels. A
// round-robin scheduler grants one channel per cycle; the granted channel's
// history is shifted, compared against PATTERN, and a match is reported one
// cycle later tagged with the channel ID.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : seq_detect_scheduler_if.slave (enable, ch_valid, ch_bit,
//            clear_ch -> ch_ready, det_valid, det_ch [, rd_ch -> rd_count])
// Optional feature macro: MATCH_COUNT_EN adds per-channel 8-bit saturating
// match counters readable through rd_ch/rd_count.
// ---------------------------------------------------------------------------
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int                 N_CH    = 4,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input logic                   clk,
  input logic                   reset,
  seq_detect_scheduler_if.slave bus
);

  localparam int CH_W  = chWidth(N_CH);
  localparam int CNT_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] hist_q [N_CH];
  logic [PAT_LEN-1:0] hist_d [N_CH];
  logic [CNT_W-1:0]   cnt_q  [N_CH];
  logic [CNT_W-1:0]   cnt_d  [N_CH];
  logic [CH_W-1:0]    rr_q, rr_d;
  logic               det_valid_q, det_valid_d;
  logic [CH_W-1:0]    det_ch_q, det_ch_d;

  logic [N_CH-1:0]    eligible;
  logic [N_CH-1:0]    grant;
  logic [CH_W-1:0]    grantIdx;
  logic               grantValid;
  logic [PAT_LEN-1:0] shifted;
  logic               match;

  // A clear masks its own channel, so clear always wins over a transfer.
  assign eligible = bus.ch_valid & ~bus.clear_ch & {N_CH{bus.enable & ~reset}};

  rr_arbiter #(
    .N_REQ (N_CH),
    .IDX_W (CH_W)
  ) u_arb (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (grantIdx),
    .valid_o (grantValid)
  );

  assign bus.ch_ready  = grant;
  assign bus.det_valid = det_valid_q;
  assign bus.det_ch    = det_ch_q;

  // Shared compare: the granted channel's history with the incoming bit,
  // qualified by having seen at least PAT_LEN bits including this one.
  always_comb begin
    shifted = {hist_q[grantIdx][PAT_LEN-2:0], bus.ch_bit[grantIdx]};
    match   = grantValid && (shifted == PATTERN) &&
              (cnt_q[grantIdx] >= CNT_W'(PAT_LEN - 1));
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hist_d[i] = hist_q[i];
      cnt_d[i]  = cnt_q[i];
      if (bus.clear_ch[i]) begin
        hist_d[i] = '0;
        cnt_d[i]  = '0;
      end else if (grant[i]) begin
        hist_d[i] = {hist_q[i][PAT_LEN-2:0], bus.ch_bit[i]};
        if (cnt_q[i] != CNT_W'(PAT_LEN)) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rr_d = rr_q;
    if (grantValid) begin
      rr_d = (grantIdx == CH_W'(N_CH - 1)) ? '0 : grantIdx + 1'b1;
    end
    det_valid_d = match;
    det_ch_d    = match ? grantIdx : det_ch_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q        <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= hist_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_q        <= rr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [COUNT_W-1:0] mcnt_q [N_CH];
  logic [COUNT_W-1:0] mcnt_d [N_CH];

  // Counters bump on the same edge that raises det_valid and stick at max.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mcnt_d[i] = mcnt_q[i];
      if (bus.clear_ch[i]) begin
        mcnt_d[i] = '0;
      end else if (match && (grantIdx == CH_W'(i)) && (mcnt_q[i] != '1)) begin
        mcnt_d[i] = mcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        mcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mcnt_q[i] <= mcnt_d[i];
      end
    end
  end

  // Out-of-range selects read as zero when N_CH is not a power of two.
  assign bus.rd_count = (int'(bus.rd_ch) < N_CH) ? mcnt_q[bus.rd_ch] : '0;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_scheduler
// Drives directed scenarios and a long randomized run into the shared pattern
// detector, comparing grants, match pulses and (when MATCH_COUNT_EN is
// defined) match counters against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_seq_detect_scheduler;

  localparam int              N_CH    = 4;
  localparam int              PAT_LEN = 7;
  localparam int              CH_W    = 2;
  localparam logic [PAT_LEN-1:0] PATTERN = 7'b0110110;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detect_scheduler_if #(.N_CH(N_CH), .CH_W(CH_W)) bus ();

  seq_detect_scheduler #(
    .N_CH    (N_CH),
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model: each channel keeps the bits received since its last
  // clear/reset (only the newest PAT_LEN matter).
  bit seqQ [N_CH][$];
  int ptr;
  bit detV;
  int detCh;
  int matchCnt [N_CH];

  int checks;
  int errors;
  int detSeen;
  int detChSeen;
  int lastGrant;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit lastBitsMatch(input int ch);
    logic [31:0] val;
    val = '0;
    if (seqQ[ch].size() < PAT_LEN) return 1'b0;
    foreach (seqQ[ch][k]) val = (val << 1) | 32'(seqQ[ch][k]);
    return val[PAT_LEN-1:0] == PATTERN;
  endfunction

  // One clock cycle: drive inputs, check registered outputs from the previous
  // edge, check this cycle's grant, then advance the model across the edge.
  task automatic applyStimulus(input bit rst, input bit en,
                               input logic [N_CH-1:0] v,
                               input logic [N_CH-1:0] b,
                               input logic [N_CH-1:0] clr);
    logic [N_CH-1:0] expReady;
    int g;
    bit match;
    @(negedge clk);
    reset        = rst;
    bus.enable   = en;
    bus.ch_valid = v;
    bus.ch_bit   = b;
    bus.clear_ch = clr;
`ifdef MATCH_COUNT_EN
    bus.rd_ch    = CH_W'($urandom_range(0, N_CH - 1));
`endif
    #1;
    checkOutput("det_valid", 32'(bus.det_valid), 32'(detV));
    checkOutput("det_ch", 32'(bus.det_ch), 32'(detCh));
`ifdef MATCH_COUNT_EN
    checkOutput("rd_count", 32'(bus.rd_count), 32'(matchCnt[bus.rd_ch]));
`endif
    if (bus.det_valid === 1'b1) begin
      detSeen++;
      detChSeen = int'(bus.det_ch);
    end

    g = -1;
    if (!rst && en) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        int j;
        j = (ptr + k) % N_CH;
        if (v[j] && !clr[j]) g = j;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("ch_ready", 32'(bus.ch_ready), 32'(expReady));
    lastGrant = g;

    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        seqQ[i].delete();
        matchCnt[i] = 0;
      end
      ptr   = 0;
      detV  = 1'b0;
      detCh = 0;
    end else begin
      match = 1'b0;
      if (g >= 0) begin
        seqQ[g].push_back(b[g]);
        if (seqQ[g].size() > PAT_LEN) void'(seqQ[g].pop_front());
        match = lastBitsMatch(g);
        ptr   = (g + 1) % N_CH;
      end
      detV = match;
      if (match) begin
        detCh = g;
        if (matchCnt[g] < 255) matchCnt[g]++;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i]) begin
          seqQ[i].delete();
          matchCnt[i] = 0;
        end
      end
    end
  endtask

  // Streams n bits (MSB of the low n bits first) on a single channel.
  task automatic sendBits(input int ch, input logic [15:0] bits, input int n);
    logic [N_CH-1:0] v;
    logic [N_CH-1:0] b;
    for (int k = n - 1; k >= 0; k--) begin
      v = '0;
      b = '0;
      v[ch] = 1'b1;
      b[ch] = bits[k];
      applyStimulus(1'b0, 1'b1, v, b, '0);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, '0, '0, '0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b1, '0, '0, '0);
  endtask

  initial begin
    logic [15:0] pat;
    int k2;
    logic [N_CH-1:0] v;
    logic [N_CH-1:0] b;
    logic [N_CH-1:0] clr;

    checks    = 0;
    errors    = 0;
    detSeen   = 0;
    detChSeen = 0;
    ptr       = 0;
    detV      = 1'b0;
    detCh     = 0;
    for (int i = 0; i < N_CH; i++) matchCnt[i] = 0;
    pat = 16'(PATTERN);

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.ch_valid = '0;
    bus.ch_bit   = '0;
    bus.clear_ch = '0;
`ifdef MATCH_COUNT_EN
    bus.rd_ch    = '0;
`endif

    $display("[TB] reset and single-channel pattern");
    resetCycle();
    resetCycle();
    detSeen = 0;
    sendBits(0, pat >> 1, PAT_LEN - 1);
    checkOutput("no early pulse", 32'(detSeen), 32'd0);
    sendBits(0, pat, 1);
    idleCycle();
    checkOutput("single match", 32'(detSeen), 32'd1);
    checkOutput("single match ch", 32'(detChSeen), 32'd0);

    $display("[TB] overlapping match");
    resetCycle();
    detSeen = 0;
    sendBits(0, pat, PAT_LEN);
    sendBits(0, 16'b110, 3);
    idleCycle();
    checkOutput("overlap pulses", 32'(detSeen), 32'd2);

    $display("[TB] all channels valid, channel 2 carries the pattern");
    resetCycle();
    detSeen = 0;
    k2 = 0;
    for (int c = 0; c < 8 * N_CH; c++) begin
      b = '0;
      if (k2 < PAT_LEN) b[2] = PATTERN[PAT_LEN - 1 - k2];
      applyStimulus(1'b0, 1'b1, '1, b, '0);
      if (lastGrant == 2) k2++;
    end
    idleCycle();
    checkOutput("ch2 pulses", 32'(detSeen), 32'd1);
    checkOutput("ch2 det_ch", 32'(detChSeen), 32'd2);

    $display("[TB] channels 1 and 3 from pointer 2");
    resetCycle();
    applyStimulus(1'b0, 1'b1, 4'b0010, '0, '0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 4'b1010, '0, '0);

    $display("[TB] clear during a partial pattern");
    resetCycle();
    detSeen = 0;
    sendBits(1, pat >> 2, PAT_LEN - 2);
    applyStimulus(1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0010);
    sendBits(1, 16'b10, 2);
    idleCycle();
    checkOutput("clear no match", 32'(detSeen), 32'd0);
    sendBits(1, pat, PAT_LEN);
    idleCycle();
    checkOutput("clear full match", 32'(detSeen), 32'd1);

    $display("[TB] reset mid-pattern");
    resetCycle();
    detSeen = 0;
    sendBits(0, pat >> 1, PAT_LEN - 1);
    resetCycle();
    sendBits(0, pat, 1);
    idleCycle();
    checkOutput("reset discards", 32'(detSeen), 32'd0);

    $display("[TB] enable paused mid-pattern");
    resetCycle();
    detSeen = 0;
    sendBits(0, pat >> 3, PAT_LEN - 3);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 4'b0001, 4'b0001, '0);
    sendBits(0, pat & 16'h7, 3);
    idleCycle();
    checkOutput("enable resume", 32'(detSeen), 32'd1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      v   = N_CH'($urandom);
      b   = N_CH'($urandom);
      clr = N_CH'($urandom & $urandom & $urandom & $urandom);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                    v, b, clr);
    end
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
